// File: rtl/dkong_wav_fetch.sv
// dkong_wav_fetch: fetches one wave ROM byte at each 11025 Hz sample strobe,
// converts it to a signed, volume-scaled 16-bit PCM sample, and decays the
// output to zero while the sequencer is idle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no fetch outstanding; a strobe starts a fetch or a decay step
// WAIT  | ROM request raised, waiting for ack or for the timeout
// CALC  | byte latched, scaling it and updating O_WAV this cycle
module dkong_wav_fetch #(
    parameter int TIMEOUT    = 64,
    parameter int DECAY_STEP = 256
) (
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic        I_SAMPLE_PLS,
    input  logic        I_ACTIVE,
    input  logic [18:0] I_ROM_AB,
    input  logic [3:0]  I_VOL,
    output logic        O_ROM_REQ,
    output logic [18:0] O_ROM_ADDR,
    input  logic        I_ROM_ACK,
    input  logic [7:0]  I_ROM_DATA,
    output logic [15:0] O_WAV,
    output logic        O_WAV_STB,
    output logic        O_OVERRUN,
    output logic        O_TIMEOUT
);

    // One spare bit so TIMEOUT itself is representable for any power of two.
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic signed [15:0] STEP_POS = 16'(DECAY_STEP);
    localparam logic signed [15:0] STEP_NEG = -STEP_POS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CALC = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           req_q, req_d;
    logic [18:0]    addr_q, addr_d;
    logic [7:0]     byte_q, byte_d;
    logic [15:0]    wav_q, wav_d;
    logic           stb_q, stb_d;
    logic           ovr_q, ovr_d;
    logic           tmo_q, tmo_d;

    logic signed [15:0] wav_s;
    logic signed [15:0] decay_val;
    logic signed [12:0] smp_ext;
    logic signed [12:0] vol_ext;
    logic signed [12:0] prod;
    logic        [15:0] calc_val;

    // Next decay value: step toward zero, snapping to zero inside one step.
    always_comb begin
        wav_s = $signed(wav_q);
        if (wav_s >= STEP_POS) begin
            decay_val = wav_s - STEP_POS;
        end else if (wav_s <= STEP_NEG) begin
            decay_val = wav_s + STEP_POS;
        end else begin
            decay_val = 16'sd0;
        end
    end

    // Offset-binary byte to signed, times unsigned volume, then x8 to 16 bits.
    always_comb begin
        smp_ext  = {{5{~byte_q[7]}}, ~byte_q[7], byte_q[6:0]};
        vol_ext  = {9'd0, I_VOL};
        prod     = smp_ext * vol_ext;
        calc_val = {prod, 3'b000};
    end

    // Next-state and output logic of the fetch sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        addr_d  = addr_q;
        byte_d  = byte_q;
        wav_d   = wav_q;
        stb_d   = 1'b0;
        ovr_d   = 1'b0;
        tmo_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (I_SAMPLE_PLS) begin
                    if (I_ACTIVE) begin
                        addr_d  = I_ROM_AB;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        wav_d = decay_val;
                        stb_d = (decay_val != wav_s);
                    end
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (I_SAMPLE_PLS) begin
                    ovr_d = 1'b1;
                end
                // Ack takes priority over a timeout landing in the same cycle.
                if (I_ROM_ACK) begin
                    byte_d  = I_ROM_DATA;
                    req_d   = 1'b0;
                    state_d = ST_CALC;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_CALC: begin
                if (I_SAMPLE_PLS) begin
                    ovr_d = 1'b1;
                end
                wav_d   = calc_val;
                stb_d   = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            byte_q  <= '0;
            wav_q   <= '0;
            stb_q   <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            wav_q   <= wav_d;
            stb_q   <= stb_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign O_ROM_REQ  = req_q;
    assign O_ROM_ADDR = addr_q;
    assign O_WAV      = wav_q;
    assign O_WAV_STB  = stb_q;
    assign O_OVERRUN  = ovr_q;
    assign O_TIMEOUT  = tmo_q;

endmodule

// File: doc/dkong_wav_fetch.md
Name: dkong_wav_fetch

Overview:
- Downstream of the walk/jump wave sequencer.
- Turns the sequencer's 19-bit wave ROM byte address into PCM audio samples.
- At each 11025 Hz sample strobe it reads one byte from the shared wave ROM port over a request/acknowledge handshake, converts it from unsigned to signed, and scales it by a volume setting.
- Holds the result as a 16-bit signed output for the sound mixer; when the sequencer goes idle it decays the output to zero to avoid clicks.

Parameters:
- TIMEOUT, 64: maximum cycles to wait for I_ROM_ACK before abandoning a fetch.
- DECAY_STEP, 256: magnitude step toward zero applied to O_WAV per strobe while idle.

Ports:
- I_CLK  input  1  system clock.
- I_RST  input  1  synchronous reset, active-high.
- I_SAMPLE_PLS  input  1  one-cycle 11025 Hz sample strobe.
- I_ACTIVE  input  1  high while the sequencer is playing a sound.
- I_ROM_AB  input  19  byte address of the current sample, from the sequencer.
- I_VOL  input  4  unsigned volume, 0 = mute, 15 = full.
- O_ROM_REQ  output  1  ROM read request, level.
- O_ROM_ADDR  output  19  address registered with the request.
- I_ROM_ACK  input  1  one-cycle pulse; I_ROM_DATA is valid in that cycle.
- I_ROM_DATA  input  8  unsigned sample, 0x80 = silence.
- O_WAV  output  16  signed PCM sample.
- O_WAV_STB  output  1  one-cycle pulse whenever O_WAV is updated.
- O_OVERRUN  output  1  one-cycle pulse when a strobe is dropped.
- O_TIMEOUT  output  1  one-cycle pulse when a fetch is abandoned.

Behaviour:
- Reset values: O_ROM_REQ=0, O_ROM_ADDR=0, O_WAV=0, O_WAV_STB=0, O_OVERRUN=0, O_TIMEOUT=0; state IDLE; timeout counter 0.
- IDLE, strobe with I_ACTIVE=1:
  - Next cycle: O_ROM_ADDR<=I_ROM_AB sampled in the strobe cycle; O_ROM_REQ<=1; state WAIT; counter cleared.
- IDLE, strobe with I_ACTIVE=0 (decay, no ROM access):
  - O_WAV moves toward 0 by DECAY_STEP.
  - If |O_WAV| < DECAY_STEP, O_WAV becomes 0.
  - O_WAV_STB pulses next cycle only if the value changed.
- WAIT:
  - O_ROM_REQ and O_ROM_ADDR held stable.
  - Counter increments each cycle.
  - On I_ROM_ACK: O_ROM_REQ<=0 next cycle; state CALC; byte latched.
- WAIT timeout:
  - If the counter reaches TIMEOUT-1 without ack: O_ROM_REQ<=0, O_TIMEOUT pulses, O_WAV unchanged, no O_WAV_STB, state IDLE.
  - An ack arriving in the same cycle as the timeout wins; no O_TIMEOUT.
- CALC (one cycle):
  - s = byte XOR 0x80, interpreted as signed 8-bit.
  - p = s * I_VOL, signed 13-bit.
  - O_WAV <= sign-extend(p) << 3, range -15360..+15240.
  - O_WAV_STB pulses in the following cycle, aligned with the new O_WAV.
  - State IDLE.
- Latency: strobe at cycle T, O_ROM_REQ high at T+1; ack at cycle A, O_WAV and O_WAV_STB at A+2.
- Overrun: a strobe arriving in WAIT or CALC is dropped, O_OVERRUN pulses next cycle, and the fetch in progress completes normally.
- Mid-fetch changes: I_ACTIVE falling during WAIT does not cancel the fetch; decay starts at the next strobe.
- I_VOL is sampled in CALC; I_VOL=0 yields O_WAV=0.
- Acks outside WAIT are ignored.
- Address: I_ROM_AB is passed through without modification, including wrap or repeat values.
- Reset mid-operation: reset in WAIT drops O_ROM_REQ the next cycle and clears all state; a late ack is ignored.

Test Plan:
- Reset, then strobe with I_ACTIVE=1 and I_ROM_AB=0x13000; ack after 3 cycles with data 0xFF, I_VOL=15 -> O_ROM_ADDR=0x13000; REQ high 4 cycles; O_WAV=0x3B88 (15240) with a one-cycle O_WAV_STB.
- Data 0x00 with I_VOL=15 -> O_WAV=-15360 (0xC400); data 0x80 -> O_WAV=0; data 0x81 with I_VOL=1 -> O_WAV=8.
- Never ack, TIMEOUT=64 -> REQ drops after 64 cycles, O_TIMEOUT pulses once, O_WAV keeps its prior value.
- Second strobe while in WAIT -> O_OVERRUN pulses once; first fetch completes; exactly one O_WAV_STB.
- O_WAV=600, I_ACTIVE=0, three strobes -> O_WAV goes 344, 88, 0; a fourth strobe gives no O_WAV_STB; no O_ROM_REQ throughout.
- Assert I_RST during WAIT, then ack 2 cycles later -> REQ low, O_WAV=0, no O_WAV_STB, state IDLE.
